mod_matrix: RTL
===============

# mod_matrix

Parametrised routing-and-gain matrix for the synth signal path, next generation of the fixed 10×11 patch matrix. Any of NOUT module inputs (mixer, multiplier, echo, modulator, line out, …) selects one of NIN sources (oscillators, envelope, mic, …) or mute, with a per-route gain. Evaluation is time-multiplexed on one multiplier, once per audio sample. Route changes are double-buffered, and optionally de-clicked, so CPU writes never glitch the audio.

## Interface
- BITSIZE, 16, sample width, signed two's complement
- NIN, 10, number of sources
- NOUT, 11, number of destinations
- GAINBITS, 8, unsigned gain width, Q1.(GAINBITS-1); unity = 1<<(GAINBITS-1)
- RAMP_STEP, 8, gain step per sample when de-click is compiled in
- Derived: SEL_W = $clog2(NIN+1); OUT_W = $clog2(NOUT)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- sample_stb  in  1  one-cycle pulse per audio sample, already synchronised to clk
- in_flat  in  NIN*BITSIZE  source samples; source i at [i*BITSIZE +: BITSIZE]
- cfg_wr  in  1  write one shadow route entry
- cfg_out  in  OUT_W  destination index
- cfg_sel  in  SEL_W  source index; value NIN means mute
- cfg_gain  in  GAINBITS  route gain
- out_flat  out  NOUT*BITSIZE  destination samples, same packing as in_flat
- out_valid  out  1  one-cycle pulse when out_flat updates
- busy  out  1  evaluation in progress
- overrun  out  1  sticky; sample_stb arrived while busy

## Operation
- Reset values:
  - out_flat = 0; out_valid = 0; busy = 0; overrun = 0.
  - Shadow and active entries: sel = NIN (mute), gain = unity.
  - De-click current gain = 0; de-click state IDLE.
- Config writes:
  - cfg_wr writes the shadow entry for cfg_out.
  - A cfg_out ≥ NOUT is ignored.
  - A later write to the same entry overwrites the earlier one.
- Commit:
  - On an accepted sample_stb, in_flat is latched into an input buffer.
  - In the same cycle, shadow entries are copied to active entries (see Configuration).
  - A cfg_wr in the same cycle as sample_stb lands in shadow only and commits at the next sample_stb.
- FSM states: IDLE → RUN → DONE → IDLE.
  - IDLE → RUN on sample_stb.
  - RUN: a counter k runs 0..NOUT-1, one destination per cycle. The result goes into a working register.
  - RUN → DONE when k = NOUT-1.
  - DONE: copy all working registers to out_flat, pulse out_valid, then return to IDLE.
- Arithmetic per destination:
  - p = in[sel] (signed BITSIZE) × {0,gain} (signed GAINBITS+1); p has BITSIZE+GAINBITS+1 bits.
  - r = p >>> (GAINBITS-1), arithmetic shift, truncating toward −∞.
  - Saturate r to [−2^(BITSIZE-1), 2^(BITSIZE-1)−1].
  - sel = NIN yields 0.
- sample_stb while busy or in DONE:
  - Ignored: no relatch, no commit.
  - overrun set; it clears only on reset.
- rst_n asserted mid-evaluation: abort immediately, all state returns to reset values, no out_valid.

## Timing
- sample_stb in cycle 0.
- busy is high in cycles 1..NOUT+1.
- out_valid and the out_flat update occur together, in cycle NOUT+1.
- All destinations update atomically.
- Latency is NOUT+1 cycles; minimum sample_stb spacing is NOUT+2 cycles.
- At 49.152 MHz / 48 kHz the budget is 1024 cycles, so NOUT ≤ 1022.

## Configuration
- MOD_MATRIX_DECLICK_EN undefined:
  - At commit, active = shadow for all entries.
  - Route and gain changes are audible on the very next sample.
- MOD_MATRIX_DECLICK_EN defined: each destination keeps a current gain g and a state IDLE/FADE_OUT/FADE_IN, updated once per sample at its RUN slot.
  - Same sel, different gain: g moves toward the shadow gain by RAMP_STEP, clamped so it never overshoots. The new sel is not involved.
  - Different sel: FADE_OUT decrements g by min(RAMP_STEP, g). When g = 0, active sel = shadow sel and the state goes to FADE_IN.
  - FADE_IN: g ramps up to the shadow gain, then the state returns to IDLE.
  - A shadow change during a fade retargets without restarting. If the new sel equals the currently active sel, go straight to FADE_IN.
  - The multiplier uses g, not the shadow gain.

## Structure
- Package mod_matrix_pkg holds:
  - FSM state enum and de-click state enum.
  - sat_to_bits function.
  - Localparam helpers for SEL_W and OUT_W.
- Sub-module mod_matrix_gain: combinational signed multiply, shift and saturate. It is instantiated once and shared across all RUN slots.

## Test plan
- Reset, no writes, sample_stb with all inputs 0x1234:
  - out_valid in cycle NOUT+1.
  - All outputs 0 (muted).
- Route out3 ← in7, gain 0x80, in7 = −1000, strobe:
  - out3 = −1000; every other output is 0.
  - With DECLICK_EN: ramps 8, 16, … until reaching −1000 after 16 samples.
- Gain 0xFF with in0 = 0x7000:
  - Saturates to 0x7FFF.
  - With in0 = 0x9000, saturates to 0x8000.
- cfg_wr in the same cycle as sample_stb:
  - The old route is used for that sample.
  - The new route is used from the next sample.
- Second sample_stb 3 cycles after the first:
  - Ignored; overrun = 1 and stays 1.
  - out_valid is pulsed exactly once.
- rst_n pulsed low at cycle 4 of RUN:
  - No out_valid; outputs 0.
  - The next strobe evaluates normally.

Source files
------------

// File: rtl/mod_matrix_pkg.sv
// mod_matrix_pkg: shared types and helpers for the routing-and-gain matrix.
//   - mm_state_e : evaluation sequencer states
//   - dk_state_e : per-destination de-click states (used with MOD_MATRIX_DECLICK_EN)
//   - sel_w/out_w: widths of the source-select and destination-index fields
//   - sat_to_bits: clamp a signed value into a signed field of 'bits' width
package mod_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mm_state_e;

    typedef enum logic [1:0] {
        DK_IDLE,
        DK_FADE_OUT,
        DK_FADE_IN
    } dk_state_e;

    // One extra code above the last source encodes mute.
    function automatic int sel_w(input int nin);
        return $clog2(nin + 1);
    endfunction

    function automatic int out_w(input int nout);
        return (nout > 1) ? $clog2(nout) : 1;
    endfunction

    function automatic logic signed [63:0] sat_to_bits(input logic signed [63:0] v,
                                                        input int unsigned      bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mod_matrix_gain.sv
// mod_matrix_gain: combinational gain stage shared by every destination slot.
//   x_i    : signed source sample
//   gain_i : unsigned gain, Q1.(GAINBITS-1)
//   y_o    : (x_i * gain_i) >>> (GAINBITS-1), floored and saturated to BITSIZE
module mod_matrix_gain
    import mod_matrix_pkg::*;
#(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
) (
    input  logic signed [BITSIZE-1:0]  x_i,
    input  logic        [GAINBITS-1:0] gain_i,
    output logic        [BITSIZE-1:0]  y_o
);

    localparam int PW = BITSIZE + GAINBITS + 1;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        // Zero-extend the gain so it is never read as negative.
        prod    = PW'(x_i) * PW'($signed({1'b0, gain_i}));
        shifted = prod >>> (GAINBITS - 1);
        y_o     = BITSIZE'(sat_to_bits(64'(shifted), BITSIZE));
    end

endmodule

// File: rtl/mod_matrix.sv
// mod_matrix: time-multiplexed NIN-source x NOUT-destination routing matrix with
// per-route gain. One destination is evaluated per cycle after each accepted
// sample_stb; all outputs update together with a one-cycle out_valid pulse.
// Optional feature macro: MOD_MATRIX_DECLICK_EN (per-destination gain ramping).
//   clk, rst_n          : clock, asynchronous active-low reset
//   sample_stb          : one pulse per audio sample
//   in_flat             : packed source samples
//   cfg_wr/out/sel/gain : shadow route write port (sel == NIN mutes)
//   out_flat, out_valid : packed destination samples and update strobe
//   busy, overrun       : evaluation in progress; sticky strobe-while-busy flag
module mod_matrix
    import mod_matrix_pkg::*;
#(
    parameter int  BITSIZE   = 16,
    parameter int  NIN       = 10,
    parameter int  NOUT      = 11,
    parameter int  GAINBITS  = 8,
    parameter int  RAMP_STEP = 8,
    localparam int SEL_W     = sel_w(NIN),
    localparam int OUT_W     = out_w(NOUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_stb,
    input  logic [NIN*BITSIZE-1:0]  in_flat,
    input  logic                    cfg_wr,
    input  logic [OUT_W-1:0]        cfg_out,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [GAINBITS-1:0]     cfg_gain,
    output logic [NOUT*BITSIZE-1:0] out_flat,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [GAINBITS-1:0] UNITY  = {1'b1, {(GAINBITS-1){1'b0}}};
    localparam logic [SEL_W-1:0]    MUTE   = SEL_W'(NIN);
    localparam logic [OUT_W-1:0]    K_LAST = OUT_W'(NOUT - 1);
    localparam logic [OUT_W:0]      NOUT_C = (OUT_W + 1)'(NOUT);

    mm_state_e          state_q, state_d;
    logic [OUT_W-1:0]   k_q, k_d;
    logic               accept;
    logic               overrun_q, overrun_d;
    logic               out_valid_q;

    logic [BITSIZE-1:0]  in_buf_q   [NIN];
    logic [SEL_W-1:0]    shd_sel_q  [NOUT];
    logic [GAINBITS-1:0] shd_gain_q [NOUT];
    logic [SEL_W-1:0]    act_sel_q  [NOUT];
    logic [BITSIZE-1:0]  work_q     [NOUT];
    logic [BITSIZE-1:0]  out_q      [NOUT];

    logic [SEL_W-1:0]    cur_sel;
    logic [GAINBITS-1:0] cur_gain;
    logic [BITSIZE-1:0]  x_src;
    logic [BITSIZE-1:0]  res;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (sample_stb) begin
                state_d = ST_RUN;
                k_d     = '0;
                accept  = 1'b1;
            end
            ST_RUN: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign overrun_d = overrun_q | (sample_stb & busy);
    assign overrun   = overrun_q;
    assign out_valid = out_valid_q;

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < NOUT; i++) out_flat[i*BITSIZE +: BITSIZE] = out_q[i];
    end

    assign x_src = (cur_sel < MUTE) ? in_buf_q[cur_sel] : '0;

    mod_matrix_gain #(
        .BITSIZE  (BITSIZE),
        .GAINBITS (GAINBITS)
    ) u_gain (
        .x_i    (x_src),
        .gain_i (cur_gain),
        .y_o    (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NIN; i++) in_buf_q[i] <= '0;
            for (int i = 0; i < NOUT; i++) begin
                shd_sel_q[i]  <= MUTE;
                shd_gain_q[i] <= UNITY;
                work_q[i]     <= '0;
                out_q[i]      <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            overrun_q   <= overrun_d;
            out_valid_q <= 1'b0;
            if (cfg_wr && ({1'b0, cfg_out} < NOUT_C)) begin
                shd_sel_q[cfg_out]  <= cfg_sel;
                shd_gain_q[cfg_out] <= cfg_gain;
            end
            if (accept) begin
                for (int i = 0; i < NIN; i++) in_buf_q[i] <= in_flat[i*BITSIZE +: BITSIZE];
            end
            if (state_q == ST_RUN) begin
                work_q[k_q] <= res;
                // Last slot bypasses its working register so the whole set
                // lands in out_q on the same edge that raises out_valid.
                if (k_q == K_LAST) begin
                    for (int i = 0; i < NOUT; i++)
                        out_q[i] <= (OUT_W'(i) == k_q) ? res : work_q[i];
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

`ifdef MOD_MATRIX_DECLICK_EN
    localparam logic [GAINBITS-1:0] STEP = GAINBITS'(RAMP_STEP);

    // Targets are frozen at commit so mid-evaluation writes wait a sample.
    logic [SEL_W-1:0]    tgt_sel_q  [NOUT];
    logic [GAINBITS-1:0] tgt_gain_q [NOUT];
    logic [GAINBITS-1:0] g_q        [NOUT];
    dk_state_e           dk_q       [NOUT];

    logic [SEL_W-1:0]    ts, nsel;
    logic [GAINBITS-1:0] tg, ng;
    dk_state_e           ndk;

    always_comb begin
        nsel = act_sel_q[k_q];
        ng   = g_q[k_q];
        ndk  = dk_q[k_q];
        ts   = tgt_sel_q[k_q];
        tg   = tgt_gain_q[k_q];
        if ((nsel != ts) && (ng != '0)) begin
            ng  = (ng > STEP) ? ng - STEP : '0;
            ndk = DK_FADE_OUT;
            if (ng == '0) begin
                nsel = ts;
                ndk  = DK_FADE_IN;
            end
        end else begin
            // Either already on the target source, or silent and free to switch.
            nsel = ts;
            if (ng < tg)      ng = ((tg - ng) > STEP) ? ng + STEP : tg;
            else if (ng > tg) ng = ((ng - tg) > STEP) ? ng - STEP : tg;
            ndk = (ng == tg) ? DK_IDLE : DK_FADE_IN;
        end
        cur_sel  = nsel;
        cur_gain = ng;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOUT; i++) begin
                act_sel_q[i]  <= MUTE;
                tgt_sel_q[i]  <= MUTE;
                tgt_gain_q[i] <= UNITY;
                g_q[i]        <= '0;
                dk_q[i]       <= DK_IDLE;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < NOUT; i++) begin
                    tgt_sel_q[i]  <= shd_sel_q[i];
                    tgt_gain_q[i] <= shd_gain_q[i];
                end
            end
            if (state_q == ST_RUN) begin
                act_sel_q[k_q] <= nsel;
                g_q[k_q]       <= ng;
                dk_q[k_q]      <= ndk;
            end
        end
    end
`else
    logic [GAINBITS-1:0] act_gain_q [NOUT];

    assign cur_sel  = act_sel_q[k_q];
    assign cur_gain = act_gain_q[k_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOUT; i++) begin
                act_sel_q[i]  <= MUTE;
                act_gain_q[i] <= UNITY;
            end
        end else if (accept) begin
            for (int i = 0; i < NOUT; i++) begin
                act_sel_q[i]  <= shd_sel_q[i];
                act_gain_q[i] <= shd_gain_q[i];
            end
        end
    end
`endif

endmodule
